// File: rtl/xc_malu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xc_malu_pkg                                               |
// | Brief    : Shared state encoding and constants for the long-arith    |
// |            multi-cycle ALU sequencer.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package xc_malu_pkg;

  // Sequencer states, 3-bit encoding shared with the datapath.
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_MSUB_1 = 3'd1,
    S_MACC_1 = 3'd2,
    S_MMUL_1 = 3'd3,
    S_MMUL_2 = 3'd4,
    S_MMUL_3 = 3'd5,
    S_DONE   = 3'd6
  } malu_state_t;

  // Default number of shift-add multiply iterations.
  localparam int MMUL_STEPS_DEFAULT = 32;

  // True when exactly one bit of the operation select is set.
  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xc_malu_long_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xc_malu_long_seq                                          |
// | Brief    : Control sequencer for the long-arithmetic multi-cycle ALU |
// |            (madd / msub / macc / mmul). Owns acc, carry and the      |
// |            multiply step counter; datapath and multiplier are        |
// |            external.                                                 |
// | Options  : XC_MALU_LONG_MMUL_EN - when defined, implements the mmul  |
// |            sequence; otherwise mmul is reported as unsupported.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module xc_malu_long_seq
  import xc_malu_pkg::*;
#(
  parameter int MMUL_STEPS = MMUL_STEPS_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic [63:0] long_n_acc,
  input  logic        long_n_carry,
  input  logic [63:0] mul_n_acc,
  output logic        fsm_init,
  output logic        fsm_msub_1,
  output logic        fsm_macc_1,
  output logic        fsm_mmul_1,
  output logic        fsm_mmul_2,
  output logic        fsm_done,
  output logic [63:0] acc,
  output logic        carry,
  output logic [5:0]  count,
  output logic        ready,
  output logic        uop_bad
);

  malu_state_t state;
  logic [3:0]  uops;
  logic        req;
  logic        abort;
  logic        init_madd;

  assign uops = {uop_mmul, uop_macc, uop_msub, uop_madd};

  // A request is only honoured when exactly one operation is selected.
  assign req = valid && is_one_hot4(uops);

  // Losing valid mid-operation is treated exactly like a flush; DONE
  // always returns to INIT so it is not an abort there.
  assign abort = flush || (!valid && (state != S_INIT) && (state != S_DONE));

  assign init_madd = fsm_init && req && uop_madd;

  assign fsm_init   = (state == S_INIT);
  assign fsm_msub_1 = (state == S_MSUB_1);
  assign fsm_macc_1 = (state == S_MACC_1);
  assign fsm_done   = (state == S_DONE);

`ifdef XC_MALU_LONG_MMUL_EN
  localparam logic [5:0] LAST_STEP = 6'(MMUL_STEPS - 1);

  assign fsm_mmul_1 = (state == S_MMUL_1);
  assign fsm_mmul_2 = (state == S_MMUL_2);
  assign uop_bad    = 1'b0;
  assign ready      = init_madd || fsm_done;
`else
  logic mmul_reject;
  logic unused_mul;
  localparam int unused_steps = MMUL_STEPS;

  // Without the multiplier, mmul completes at once and is flagged bad.
  assign mmul_reject = fsm_init && req && uop_mmul;
  assign unused_mul  = ^mul_n_acc;
  assign fsm_mmul_1  = 1'b0;
  assign fsm_mmul_2  = 1'b0;
  assign uop_bad     = mmul_reject;
  assign ready       = init_madd || fsm_done || mmul_reject;
`endif

  // Sequencer: state transitions plus acc / carry / count updates.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= S_INIT;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (abort) begin
      state <= S_INIT;
      count <= '0;
    end else begin
      count <= '0;
      case (state)
        S_INIT: begin
          if (req) begin
            if (uop_msub) begin
              acc   <= long_n_acc;
              state <= S_MSUB_1;
            end else if (uop_macc) begin
              acc   <= long_n_acc;
              carry <= long_n_carry;
              state <= S_MACC_1;
            end
`ifdef XC_MALU_LONG_MMUL_EN
            else if (uop_mmul) begin
              acc   <= '0;
              carry <= 1'b0;
              state <= S_MMUL_1;
            end
`endif
          end
        end
        S_MSUB_1: begin
          acc   <= long_n_acc;
          state <= S_DONE;
        end
        S_MACC_1: begin
          acc   <= long_n_acc;
          carry <= long_n_carry;
          state <= S_DONE;
        end
`ifdef XC_MALU_LONG_MMUL_EN
        S_MMUL_1: begin
          acc <= mul_n_acc;
          if (count == LAST_STEP) begin
            state <= S_MMUL_2;
          end else begin
            count <= count + 6'd1;
          end
        end
        S_MMUL_2: begin
          acc   <= long_n_acc;
          carry <= long_n_carry;
          state <= S_MMUL_3;
        end
        S_MMUL_3: begin
          acc   <= long_n_acc;
          carry <= long_n_carry;
          state <= S_DONE;
        end
`endif
        S_DONE:  state <= S_INIT;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_long_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_xc_malu_long_seq                                       |
// | Brief    : Self-checking bench for xc_malu_long_seq: vector table,   |
// |            hand-written corner sequences and random operations      |
// |            against a transaction-level reference model.              |
// | Options  : XC_MALU_LONG_MMUL_EN selects which mmul behaviour is      |
// |            expected.                                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_xc_malu_long_seq;

`ifdef XC_MALU_LONG_MMUL_EN
  localparam bit MMUL_EN = 1'b1;
`else
  localparam bit MMUL_EN = 1'b0;
`endif
  localparam int STEPS    = 32;
  localparam int MMUL_LAT = MMUL_EN ? (STEPS + 4) : 1;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        uop_madd = 1'b0;
  logic        uop_msub = 1'b0;
  logic        uop_macc = 1'b0;
  logic        uop_mmul = 1'b0;
  logic [63:0] long_n_acc = '0;
  logic        long_n_carry = 1'b0;
  logic [63:0] mul_n_acc = '0;
  logic        fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done;
  logic [63:0] acc;
  logic        carry;
  logic [5:0]  count;
  logic        ready;
  logic        uop_bad;

  int n_checks = 0;
  int n_fail   = 0;

  xc_malu_long_seq #(.MMUL_STEPS(STEPS)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .flush(flush),
    .uop_madd(uop_madd), .uop_msub(uop_msub), .uop_macc(uop_macc), .uop_mmul(uop_mmul),
    .long_n_acc(long_n_acc), .long_n_carry(long_n_carry), .mul_n_acc(mul_n_acc),
    .fsm_init(fsm_init), .fsm_msub_1(fsm_msub_1), .fsm_macc_1(fsm_macc_1),
    .fsm_mmul_1(fsm_mmul_1), .fsm_mmul_2(fsm_mmul_2), .fsm_done(fsm_done),
    .acc(acc), .carry(carry), .count(count), .ready(ready), .uop_bad(uop_bad)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_uops(input logic [3:0] u);
    {uop_mmul, uop_macc, uop_msub, uop_madd} = u;
  endtask

  // Strobe vector {init, msub_1, macc_1, mmul_1, mmul_2, done}.
  function automatic logic [5:0] strobes();
    return {fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done};
  endfunction

  // Issue one operation: a/ca presented in the first cycle, b/cb after.
  // Returns the cycle (1-based) at which ready was seen, 0 on timeout.
  task automatic run_op(input logic [3:0] u, input logic [63:0] a, input logic [63:0] b,
                        input logic ca, input logic cb, output int lat, output logic bad);
    lat = 0;
    bad = 1'b0;
    @(posedge g_clk); #1;
    set_uops(u);
    valid = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      long_n_acc   = (k == 1) ? a : b;
      long_n_carry = (k == 1) ? ca : cb;
      mul_n_acc    = {$urandom, $urandom};
      @(negedge g_clk);
      if (ready) begin
        lat = k;
        bad = uop_bad;
        break;
      end
      @(posedge g_clk); #1;
    end
    @(posedge g_clk); #1;
    valid = 1'b0;
    set_uops(4'b0000);
  endtask

  task automatic do_reset();
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    set_uops(4'b0000);
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  u;
    logic [63:0] a, b;
    logic        ca, cb;
    int          exp_lat;
    logic        exp_bad;
    logic [63:0] exp_acc;
    logic        exp_carry;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          lat;
    logic        bad;
    logic [63:0] model_acc;
    logic        model_carry;
    logic [3:0]  bad_uops[5];

    // ---------------- vector table ----------------
    vt[0] = '{4'b0010, 64'h5,  64'h4,  1'b1, 1'b1, 3, 1'b0, 64'h4,  1'b0};
    vt[1] = '{4'b0001, 64'hAA, 64'hBB, 1'b1, 1'b1, 1, 1'b0, 64'h4,  1'b0};
    vt[2] = '{4'b0100, 64'h11, 64'h22, 1'b0, 1'b1, 3, 1'b0, 64'h22, 1'b1};
    vt[3] = '{4'b0010, 64'h7,  64'h8,  1'b0, 1'b0, 3, 1'b0, 64'h8,  1'b1};
`ifdef XC_MALU_LONG_MMUL_EN
    vt[4] = '{4'b1000, 64'h55, 64'h99, 1'b1, 1'b0, STEPS + 4, 1'b0, 64'h99, 1'b0};
`else
    vt[4] = '{4'b1000, 64'h55, 64'h99, 1'b1, 1'b0, 1, 1'b1, 64'h8, 1'b1};
`endif
    vt[5] = '{4'b0100, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vt[6] = '{4'b0001, 64'h1, 64'h2, 1'b0, 1'b0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    bad_uops[0] = 4'b0000;
    bad_uops[1] = 4'b0011;
    bad_uops[2] = 4'b0110;
    bad_uops[3] = 4'b1100;
    bad_uops[4] = 4'b1111;

    // ---------------- reset state ----------------
    repeat (2) @(negedge g_clk);
    chk("reset acc", acc, 64'h0);
    chk("reset carry", carry, 1'b0);
    chk("reset count", count, 6'd0);
    chk("reset ready", ready, 1'b0);
    chk("reset uop_bad", uop_bad, 1'b0);
    chk("reset strobes", strobes(), 6'b100000);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].u, vt[i].a, vt[i].b, vt[i].ca, vt[i].cb, lat, bad);
      @(negedge g_clk);
      chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d uop_bad", i), bad, vt[i].exp_bad);
      chk($sformatf("vec%0d acc", i), acc, vt[i].exp_acc);
      chk($sformatf("vec%0d carry", i), carry, vt[i].exp_carry);
      chk($sformatf("vec%0d back in init", i), strobes(), 6'b100000);
    end

    // ---------------- msub strobe sequence ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b0010); long_n_acc = 64'h5;
    @(negedge g_clk);
    chk("msub c1 strobes", strobes(), 6'b100000);
    chk("msub c1 ready", ready, 1'b0);
    @(posedge g_clk); #1;
    long_n_acc = 64'h4;
    @(negedge g_clk);
    chk("msub c2 strobes", strobes(), 6'b010000);
    chk("msub c2 acc", acc, 64'h5);
    chk("msub c2 ready", ready, 1'b0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("msub c3 strobes", strobes(), 6'b000001);
    chk("msub c3 ready", ready, 1'b1);
    chk("msub c3 acc", acc, 64'h4);
    @(posedge g_clk); #1;
    valid = 1'b0; set_uops(4'b0000);
    @(negedge g_clk);
    chk("msub after strobes", strobes(), 6'b100000);

    // ---------------- flush during MSUB_1 ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b0010); long_n_acc = 64'h77;
    @(posedge g_clk); #1;
    flush = 1'b1; long_n_acc = 64'h88;
    @(negedge g_clk);
    chk("flush msub_1 strobe", fsm_msub_1, 1'b1);
    @(posedge g_clk); #1;
    flush = 1'b0; valid = 1'b0; set_uops(4'b0000);
    @(negedge g_clk);
    chk("flush -> init", strobes(), 6'b100000);
    chk("flush acc held", acc, 64'h77);
    chk("flush ready", ready, 1'b0);

    // ---------------- valid dropped during MACC_1 ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b0100); long_n_acc = 64'h1234; long_n_carry = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0; set_uops(4'b0000); long_n_acc = 64'h5678; long_n_carry = 1'b0;
    @(negedge g_clk);
    chk("vdrop ready", ready, 1'b0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("vdrop -> init", strobes(), 6'b100000);
    chk("vdrop acc held", acc, 64'h1234);
    chk("vdrop carry held", carry, 1'b1);

    // ---------------- reset during MACC_1 ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b0100); long_n_acc = 64'h33; long_n_carry = 1'b1;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("rst macc_1 strobe", fsm_macc_1, 1'b1);
    #1 g_resetn = 1'b0;
    #1;
    chk("rst async acc", acc, 64'h0);
    chk("rst async carry", carry, 1'b0);
    chk("rst async strobes", strobes(), 6'b100000);
    valid = 1'b0; set_uops(4'b0000);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      chk($sformatf("rst no ready c%0d", k), ready, 1'b0);
    end

`ifdef XC_MALU_LONG_MMUL_EN
    // ---------------- full mmul sequence ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b1000); long_n_acc = 64'hABC; long_n_carry = 1'b1;
    @(negedge g_clk);
    chk("mmul c1 strobes", strobes(), 6'b100000);
    for (int k = 0; k < STEPS; k++) begin
      @(posedge g_clk); #1;
      mul_n_acc = 64'h1000 + 64'(k);
      @(negedge g_clk);
      chk($sformatf("mmul step%0d strobes", k), strobes(), 6'b000100);
      chk($sformatf("mmul step%0d count", k), count, 6'(k));
    end
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("mmul2 strobes", strobes(), 6'b000010);
    chk("mmul2 acc", acc, 64'h1000 + 64'(STEPS - 1));
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("mmul3 strobes", strobes(), 6'b000000);
    chk("mmul3 ready", ready, 1'b0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("mmul done strobes", strobes(), 6'b000001);
    chk("mmul done ready", ready, 1'b1);
    chk("mmul done acc", acc, 64'hABC);
    @(posedge g_clk); #1;
    valid = 1'b0; set_uops(4'b0000);

    // ---------------- flush at count 10 ----------------
    @(posedge g_clk); #1;
    valid = 1'b1; set_uops(4'b1000);
    for (int k = 0; k <= 10; k++) begin
      @(posedge g_clk); #1;
      mul_n_acc = 64'h1000 + 64'(k);
      if (k == 10) flush = 1'b1;
    end
    @(negedge g_clk);
    chk("mflush count at flush", count, 6'd10);
    @(posedge g_clk); #1;
    flush = 1'b0; valid = 1'b0; set_uops(4'b0000);
    @(negedge g_clk);
    chk("mflush -> init", strobes(), 6'b100000);
    chk("mflush count", count, 6'd0);
    chk("mflush acc held", acc, 64'h1009);
    chk("mflush ready", ready, 1'b0);
`else
    // ---------------- unsupported mmul ----------------
    @(posedge g_clk); #1;
    long_n_acc = 64'hDEAD; long_n_carry = 1'b1;
    valid = 1'b1; set_uops(4'b1000);
    @(negedge g_clk);
    chk("nommul ready", ready, 1'b1);
    chk("nommul uop_bad", uop_bad, 1'b1);
    chk("nommul strobes", strobes(), 6'b100000);
    @(posedge g_clk); #1;
    valid = 1'b0; set_uops(4'b0000);
    @(negedge g_clk);
    chk("nommul acc unchanged", acc, 64'h0);
    chk("nommul carry unchanged", carry, 1'b0);
`endif

    // ---------------- random operations vs model ----------------
    do_reset();
    model_acc   = '0;
    model_carry = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [63:0] a, b;
      logic        ca, cb;
      int          exp_lat;
      logic        exp_bad;
      op = int'($urandom_range(0, 4));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      ca = 1'($urandom);
      cb = 1'($urandom);
      if (op == 4) begin
        // Non one-hot select (or none): nothing must happen.
        @(posedge g_clk); #1;
        valid = 1'b1;
        set_uops(bad_uops[$urandom_range(0, 4)]);
        long_n_acc = a; long_n_carry = ca;
        for (int k = 0; k < 3; k++) begin
          @(negedge g_clk);
          chk($sformatf("rnd%0d nonhot ready", i), {ready, uop_bad, fsm_init}, 3'b001);
          @(posedge g_clk); #1;
        end
        valid = 1'b0; set_uops(4'b0000);
        @(negedge g_clk);
        chk($sformatf("rnd%0d nonhot acc", i), acc, model_acc);
      end else begin
        run_op(4'b0001 << op, a, b, ca, cb, lat, bad);
        case (op)
          0: begin exp_lat = 1; exp_bad = 1'b0; end
          1: begin exp_lat = 3; exp_bad = 1'b0; model_acc = b; end
          2: begin exp_lat = 3; exp_bad = 1'b0; model_acc = b; model_carry = cb; end
          default: begin
            exp_lat = MMUL_LAT;
            exp_bad = !MMUL_EN;
            if (MMUL_EN) begin
              model_acc   = b;
              model_carry = cb;
            end
          end
        endcase
        @(negedge g_clk);
        chk($sformatf("rnd%0d op%0d latency", i, op), lat, exp_lat);
        chk($sformatf("rnd%0d op%0d uop_bad", i, op), bad, exp_bad);
        chk($sformatf("rnd%0d op%0d acc", i, op), acc, model_acc);
        chk($sformatf("rnd%0d op%0d carry", i, op), carry, model_carry);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xc_malu_long_seq.md
XC_MALU_LONG_SEQ -- requirements
Module: xc_malu_long_seq

Interface
REQ-001 SHALL have parameter MMUL_STEPS, default 32, number of shift-add multiply cycles (1..32).
REQ-002 SHALL have port g_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port g_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid  input  1  operation request; held high with stable operands until ready.
REQ-005 SHALL have port flush  input  1  abort the current operation.
REQ-006 SHALL have ports uop_madd, uop_msub, uop_macc, uop_mmul  input  1 each  one-hot operation select, sampled while valid.
REQ-007 SHALL have port long_n_acc  input  64  next accumulator from the long-arithmetic datapath.
REQ-008 SHALL have port long_n_carry  input  1  next carry from the long-arithmetic datapath.
REQ-009 SHALL have port mul_n_acc  input  64  next accumulator from the shift-add multiplier step.
REQ-010 SHALL have ports fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done  output  1 each  one-hot state strobes to the datapath.
REQ-011 SHALL have port acc  output  64  accumulator register.
REQ-012 SHALL have port carry  output  1  carry register.
REQ-013 SHALL have port count  output  6  multiply step counter.
REQ-014 SHALL have port ready  output  1  result available; the operation completes on valid && ready.
REQ-015 SHALL have port uop_bad  output  1  unsupported operation (see Configuration).

Function
REQ-016 SHALL implement states INIT, MSUB_1, MACC_1, MMUL_1, MMUL_2, MMUL_3, DONE; each fsm_* strobe is high only in its state, fsm_init in INIT, and no strobe is high in MMUL_3.
REQ-017 SHALL make madd a single cycle: ready is high combinationally in INIT when valid && uop_madd, and the state stays INIT.
REQ-018 SHALL sequence msub as INIT->MSUB_1->DONE, loading acc from long_n_acc in INIT and in MSUB_1.
REQ-019 SHALL sequence macc as INIT->MACC_1->DONE, loading acc and carry from long_n_acc and long_n_carry in INIT and in MACC_1.
REQ-020 SHALL sequence mmul as INIT->MMUL_1 (MMUL_STEPS cycles)->MMUL_2->MMUL_3->DONE.
REQ-021 SHALL load acc from mul_n_acc in each MMUL_1 cycle; count increments from 0 and leaves MMUL_1 when count==MMUL_STEPS-1.
REQ-022 SHALL load acc and carry from the long datapath in MMUL_2 and in MMUL_3.
REQ-023 SHALL clear acc to 0 and carry to 0 on INIT entry for mmul.
REQ-024 SHALL assert ready in DONE and return to INIT on the following cycle regardless of valid.
REQ-025 SHALL clear count to 0 in every state other than MMUL_1.
REQ-026 SHALL give priority to flush over all other inputs: the next state is INIT, count=0, and acc/carry are held.
REQ-027 SHALL treat valid deasserted outside INIT as an abort, identical to flush.
REQ-028 SHALL remain in INIT with no register update when valid is low or the uop is not one-hot; uop_bad is then 0.

Reset
REQ-029 SHALL on g_resetn low immediately set state=INIT, acc=0, carry=0, count=0; consequently ready=0 and uop_bad=0, and all fsm_* are 0 except fsm_init=1.
REQ-030 SHALL abandon an in-progress operation on reset asserted mid-operation, with no ready pulse after release.

Configuration
REQ-031 SHALL with XC_MALU_LONG_MMUL_EN defined, implement the MMUL_1..MMUL_3 states and mmul sequencing as above.
REQ-032 SHALL with XC_MALU_LONG_MMUL_EN undefined, omit the MMUL states; uop_mmul with valid gives ready=1 and uop_bad=1 in INIT in the same cycle, acc is unchanged, and fsm_mmul_1/fsm_mmul_2 are tied 0.

Structure
REQ-033 SHALL place the state encoding (3-bit) and the default MMUL_STEPS constant in a shared package xc_malu_pkg.
REQ-034 SHALL be a single module with no sub-module; the datapath and multiplier stay external.

Verification
REQ-035 SHALL cover madd: valid=1, uop_madd=1 -> ready=1 in the same cycle, fsm_init=1, state stays INIT.
REQ-036 SHALL cover msub: long_n_acc=64'h5 then 64'h4 -> fsm_msub_1 on cycle 2, ready on cycle 3, acc=64'h4.
REQ-037 SHALL cover mmul with MMUL_STEPS=32: count runs 0..31 with fsm_mmul_1=1 for 32 cycles, then fsm_mmul_2, MMUL_3, ready on cycle 36.
REQ-038 SHALL cover flush at count=10 in MMUL_1 -> next cycle INIT, count=0, acc held, no ready.
REQ-039 SHALL cover g_resetn pulled low during MACC_1 -> acc=0, carry=0, fsm_init=1 immediately, no ready after release.
REQ-040 SHALL cover the build without XC_MALU_LONG_MMUL_EN: uop_mmul valid -> ready=1, uop_bad=1 in the same cycle, acc unchanged.
